// File: rtl/lms_sample_pairer.sv
// lms_sample_pairer: buffers reference and microphone samples in two
// independent FIFOs and issues them as time-aligned pairs to an LMS
// adaptive filter, spacing issues at least MIN_GAP clocks apart.
// Optional feature macro: LMS_PAIRER_STATS_EN adds a 16-bit pair_cnt output.
module lms_sample_pairer #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned MIN_GAP = 272
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ref_data,
    input  logic        ref_valid,
    input  logic [15:0] mic_data,
    input  logic        mic_valid,
    output logic [15:0] filter_in,
    output logic        filter_en,
    output logic [15:0] desired_in,
    output logic        desired_en,
    input  logic        ovf_clr,
    output logic        ref_overflow,
    output logic        mic_overflow,
    output logic        resync
`ifdef LMS_PAIRER_STATS_EN
    ,
    output logic [15:0] pair_cnt
`endif
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(MIN_GAP);
    localparam logic [CW-1:0] GAP_LOAD = CW'(MIN_GAP - 3);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] gap_q, gap_d;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] mic_mem [DEPTH];

    logic [AW-1:0]   ref_wp_q, ref_wp_d, ref_rp_q, ref_rp_d;
    logic [AW-1:0]   mic_wp_q, mic_wp_d, mic_rp_q, mic_rp_d;
    logic [CNTW-1:0] ref_cnt_q, ref_cnt_d, mic_cnt_q, mic_cnt_d;

    logic [15:0] filter_in_q, desired_in_q;
    logic        en_q;
    logic        ref_ovf_q, ref_ovf_d, mic_ovf_q, mic_ovf_d;

    logic ref_full, ref_empty, mic_full, mic_empty;
    logic flush, pop, capture;
    logic ref_push, mic_push, ref_drop, mic_drop;

    assign ref_full  = (ref_cnt_q == CNTW'(DEPTH));
    assign mic_full  = (mic_cnt_q == CNTW'(DEPTH));
    assign ref_empty = (ref_cnt_q == '0);
    assign mic_empty = (mic_cnt_q == '0);

    // A channel that fills while its partner stays empty means the streams
    // have lost alignment; both FIFOs are discarded to restart pairing.
    assign flush = (ref_full && mic_empty) || (mic_full && ref_empty);
    assign pop   = (state_q == ISSUE);

    // Push arbitration: flush wins, a full FIFO accepts only alongside a pop.
    always_comb begin
        ref_push = ref_valid && !flush && (!ref_full || pop);
        mic_push = mic_valid && !flush && (!mic_full || pop);
        ref_drop = ref_valid && !flush && ref_full && !pop;
        mic_drop = mic_valid && !flush && mic_full && !pop;
    end

    // Pointer and occupancy next-state for both FIFOs.
    always_comb begin
        ref_wp_d  = ref_wp_q;
        ref_rp_d  = ref_rp_q;
        ref_cnt_d = ref_cnt_q;
        mic_wp_d  = mic_wp_q;
        mic_rp_d  = mic_rp_q;
        mic_cnt_d = mic_cnt_q;
        if (flush) begin
            ref_wp_d  = '0;
            ref_rp_d  = '0;
            ref_cnt_d = '0;
            mic_wp_d  = '0;
            mic_rp_d  = '0;
            mic_cnt_d = '0;
        end else begin
            ref_wp_d  = ref_wp_q + AW'(ref_push);
            ref_rp_d  = ref_rp_q + AW'(pop);
            ref_cnt_d = ref_cnt_q + CNTW'(ref_push) - CNTW'(pop);
            mic_wp_d  = mic_wp_q + AW'(mic_push);
            mic_rp_d  = mic_rp_q + AW'(pop);
            mic_cnt_d = mic_cnt_q + CNTW'(mic_push) - CNTW'(pop);
        end
    end

    // Issue FSM next-state; heads are captured on entry to ISSUE so the
    // registered outputs and the en pulse line up in the ISSUE cycle.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!ref_empty && !mic_empty) begin
                    state_d = ISSUE;
                    capture = 1'b1;
                end
            end
            ISSUE: begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky overflow flags; a same-cycle set overrides the clear.
    always_comb begin
        ref_ovf_d = ref_drop || (ref_ovf_q && !ovf_clr);
        mic_ovf_d = mic_drop || (mic_ovf_q && !ovf_clr);
    end

    // Sample storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (ref_push) ref_mem[ref_wp_q] <= ref_data;
        if (mic_push) mic_mem[mic_wp_q] <= mic_data;
    end

    // State, pointers, flags and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gap_q        <= '0;
            ref_wp_q     <= '0;
            ref_rp_q     <= '0;
            ref_cnt_q    <= '0;
            mic_wp_q     <= '0;
            mic_rp_q     <= '0;
            mic_cnt_q    <= '0;
            filter_in_q  <= '0;
            desired_in_q <= '0;
            en_q         <= 1'b0;
            ref_ovf_q    <= 1'b0;
            mic_ovf_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            ref_wp_q  <= ref_wp_d;
            ref_rp_q  <= ref_rp_d;
            ref_cnt_q <= ref_cnt_d;
            mic_wp_q  <= mic_wp_d;
            mic_rp_q  <= mic_rp_d;
            mic_cnt_q <= mic_cnt_d;
            en_q      <= capture;
            ref_ovf_q <= ref_ovf_d;
            mic_ovf_q <= mic_ovf_d;
            if (capture) begin
                filter_in_q  <= ref_mem[ref_rp_q];
                desired_in_q <= mic_mem[mic_rp_q];
            end
        end
    end

`ifdef LMS_PAIRER_STATS_EN
    logic [15:0] pair_cnt_q;

    // Issued-pair counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt_q <= '0;
        end else if (capture) begin
            pair_cnt_q <= pair_cnt_q + 16'd1;
        end
    end

    assign pair_cnt = pair_cnt_q;
`endif

    assign filter_in    = filter_in_q;
    assign desired_in   = desired_in_q;
    assign filter_en    = en_q;
    assign desired_en   = en_q;
    assign ref_overflow = ref_ovf_q;
    assign mic_overflow = mic_ovf_q;
    assign resync       = flush;

endmodule

// File: tb/tb_lms_sample_pairer.sv
// Directed self-checking bench for lms_sample_pairer (DEPTH=8, MIN_GAP=272).
module tb_lms_sample_pairer;

    logic        clk;
    logic        rst;
    logic [15:0] ref_data;
    logic        ref_valid;
    logic [15:0] mic_data;
    logic        mic_valid;
    logic [15:0] filter_in;
    logic        filter_en;
    logic [15:0] desired_in;
    logic        desired_en;
    logic        ovf_clr;
    logic        ref_overflow;
    logic        mic_overflow;
    logic        resync;
`ifdef LMS_PAIRER_STATS_EN
    logic [15:0] pair_cnt;
`endif

    int checks = 0;
    int errors = 0;

    lms_sample_pairer #(
        .DEPTH  (8),
        .MIN_GAP(272)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ref_data    (ref_data),
        .ref_valid   (ref_valid),
        .mic_data    (mic_data),
        .mic_valid   (mic_valid),
        .filter_in   (filter_in),
        .filter_en   (filter_en),
        .desired_in  (desired_in),
        .desired_en  (desired_en),
        .ovf_clr     (ovf_clr),
        .ref_overflow(ref_overflow),
        .mic_overflow(mic_overflow),
        .resync      (resync)
`ifdef LMS_PAIRER_STATS_EN
        ,
        .pair_cnt    (pair_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic [15:0] r, input logic [15:0] m);
        check1({tag, "_en"}, filter_en, 1'b1);
        check1({tag, "_den"}, desired_en, 1'b1);
        check16({tag, "_ref"}, filter_in, r);
        check16({tag, "_mic"}, desired_in, m);
    endtask

    // Advance until filter_en is seen or the budget runs out.
    task automatic wait_en(input int maxc, output int n);
        n = 0;
        while (filter_en !== 1'b1 && n < maxc) begin
            tick();
            n++;
        end
        check1("wait_en", filter_en, 1'b1);
    endtask

    task automatic push(input logic rv, input logic [15:0] rd, input logic mv, input logic [15:0] md);
        ref_valid = rv;
        ref_data  = rd;
        mic_valid = mv;
        mic_data  = md;
        tick();
        ref_valid = 1'b0;
        mic_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        ref_data  = '0;
        ref_valid = 1'b0;
        mic_data  = '0;
        mic_valid = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();

        // Reset state
        check16("rst_filter_in", filter_in, 16'h0000);
        check16("rst_desired_in", desired_in, 16'h0000);
        check1("rst_filter_en", filter_en, 1'b0);
        check1("rst_desired_en", desired_en, 1'b0);
        check1("rst_ref_ovf", ref_overflow, 1'b0);
        check1("rst_mic_ovf", mic_overflow, 1'b0);
        check1("rst_resync", resync, 1'b0);
`ifdef LMS_PAIRER_STATS_EN
        check16("rst_pair_cnt", pair_cnt, 16'h0000);
`endif
        rst = 1'b0;
        tick();

        // Ref first, mic four cycles later: issue two cycles after the mic strobe
        push(1'b1, 16'h1234, 1'b0, 16'h0000);
        tick();
        tick();
        tick();
        push(1'b0, 16'h0000, 1'b1, 16'hFEDC);
        check1("lat_en_early", filter_en, 1'b0);
        tick();
        check_pair("lat", 16'h1234, 16'hFEDC);
        tick();
        check1("lat_en_one_cycle", filter_en, 1'b0);
        check16("lat_hold_ref", filter_in, 16'h1234);
        repeat (275) tick();

        // Three back-to-back pairs: issues 272 cycles apart, in push order
        push(1'b1, 16'h0101, 1'b1, 16'hA001);
        push(1'b1, 16'h0202, 1'b1, 16'hA002);
        check_pair("b2b_p1", 16'h0101, 16'hA001);
        push(1'b1, 16'h0303, 1'b1, 16'hA003);
        check1("b2b_en_off", filter_en, 1'b0);
        wait_en(400, n);
        check16("b2b_gap1", 16'(n), 16'd271);
        check_pair("b2b_p2", 16'h0202, 16'hA002);
        tick();
        check16("b2b_hold", filter_in, 16'h0202);
        wait_en(400, n);
        check16("b2b_gap2", 16'(n), 16'd271);
        check_pair("b2b_p3", 16'h0303, 16'hA003);

        // Overflow while held in GAP: nine pushes into eight-deep FIFOs
        for (int i = 0; i < 9; i++) begin
            push(1'b1, 16'h1000 + 16'(i), 1'b1, 16'h2000 + 16'(i));
            if (i == 7) begin
                check1("ovf_ref_at_full", ref_overflow, 1'b0);
                check1("ovf_mic_at_full", mic_overflow, 1'b0);
            end
        end
        check1("ovf_ref_set", ref_overflow, 1'b1);
        check1("ovf_mic_set", mic_overflow, 1'b1);
        check1("ovf_no_resync", resync, 1'b0);
        ovf_clr = 1'b1;
        push(1'b1, 16'h10FF, 1'b1, 16'h20FF);
        ovf_clr = 1'b0;
        check1("ovf_set_beats_clr_ref", ref_overflow, 1'b1);
        check1("ovf_set_beats_clr_mic", mic_overflow, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check1("ovf_clr_ref", ref_overflow, 1'b0);
        check1("ovf_clr_mic", mic_overflow, 1'b0);

        // Drain: a push into a full FIFO alongside the pop is accepted
        wait_en(400, n);
        check_pair("drain0", 16'h1000, 16'h2000);
        push(1'b1, 16'h3000, 1'b1, 16'h4000);
        check1("popfull_ref_ovf", ref_overflow, 1'b0);
        check1("popfull_mic_ovf", mic_overflow, 1'b0);
        for (int i = 1; i < 8; i++) begin
            wait_en(400, n);
            check_pair("drain", 16'h1000 + 16'(i), 16'h2000 + 16'(i));
            tick();
        end
        wait_en(400, n);
        check_pair("drain_last", 16'h3000, 16'h4000);
        repeat (275) tick();

        // Ref fills with mic empty: resync flushes both, same-cycle push discarded
        for (int i = 0; i < 8; i++) begin
            push(1'b1, 16'h5000 + 16'(i), 1'b0, 16'h0000);
            check1("rs_en_quiet", filter_en, 1'b0);
            check1("rs_resync", resync, (i == 7));
        end
        push(1'b1, 16'h5FFF, 1'b0, 16'h0000);
        check1("rs_resync_one_cycle", resync, 1'b0);
        check1("rs_no_ovf", ref_overflow, 1'b0);
        push(1'b0, 16'h0000, 1'b1, 16'h7000);
        tick();
        check1("rs_ref_empty", filter_en, 1'b0);
        push(1'b1, 16'h6000, 1'b0, 16'h0000);
        check1("rs_en_early", filter_en, 1'b0);
        tick();
        check_pair("rs_pair", 16'h6000, 16'h7000);
        tick();

        // Async reset mid-GAP with three pairs queued
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 16'h0A00 + 16'(i), 1'b1, 16'h0D00 + 16'(i));
        end
        repeat (10) tick();
        #2;
        rst = 1'b1;
        #1;
        check16("arst_filter_in", filter_in, 16'h0000);
        check16("arst_desired_in", desired_in, 16'h0000);
        check1("arst_en", filter_en, 1'b0);
        check1("arst_resync", resync, 1'b0);
        ref_valid = 1'b1;
        ref_data  = 16'hEEEE;
        mic_valid = 1'b1;
        mic_data  = 16'hEEEE;
        tick();
        ref_valid = 1'b0;
        mic_valid = 1'b0;
        check1("arst_hold_en", filter_en, 1'b0);
        rst = 1'b0;
        tick();
        tick();
        check1("arst_queue_gone", filter_en, 1'b0);
        push(1'b1, 16'h0B0B, 1'b1, 16'h0C0C);
        check1("arst_en_early", filter_en, 1'b0);
        tick();
        check_pair("arst_pair", 16'h0B0B, 16'h0C0C);
`ifdef LMS_PAIRER_STATS_EN
        check16("stats_cnt", pair_cnt, 16'h0001);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lms_sample_pairer.md
LMS_SAMPLE_PAIRER -- requirements
Module: lms_sample_pairer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning per-channel FIFO depth in samples, power of two, minimum 2.
REQ-002 SHALL have parameter MIN_GAP, default 272, meaning minimum number of clk cycles between successive issued pairs (covers the downstream LMS iteration time).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port ref_data  input  16  meaning the signed reference (far-end/speaker) sample.
REQ-006 SHALL have port ref_valid  input  1  meaning a one-cycle strobe that qualifies ref_data.
REQ-007 SHALL have port mic_data  input  16  meaning the signed microphone (desired) sample.
REQ-008 SHALL have port mic_valid  input  1  meaning a one-cycle strobe that qualifies mic_data.
REQ-009 SHALL have port filter_in  output  16  meaning the paired reference sample sent to the adaptive filter.
REQ-010 SHALL have port filter_en  output  1  meaning a one-cycle pulse that qualifies filter_in.
REQ-011 SHALL have port desired_in  output  16  meaning the paired microphone sample.
REQ-012 SHALL have port desired_en  output  1  meaning a one-cycle pulse, always identical to filter_en.
REQ-013 SHALL have port ovf_clr  input  1  meaning a synchronous clear for both sticky overflow flags.
REQ-014 SHALL have port ref_overflow  output  1  meaning a sticky flag set when a ref sample is dropped.
REQ-015 SHALL have port mic_overflow  output  1  meaning a sticky flag set when a mic sample is dropped.
REQ-016 SHALL have port resync  output  1  meaning a one-cycle pulse indicating both FIFOs were flushed.

Function
REQ-017 SHALL buffer each channel in an independent DEPTH-entry FIFO; a valid strobe pushes one entry.
REQ-018 SHALL, when a channel's FIFO is full and its valid is asserted without a same-cycle pop, drop the new sample and set that channel's overflow flag.
REQ-019 SHALL accept a push into a full FIFO when a pop of that FIFO occurs in the same cycle.
REQ-020 SHALL implement the FSM states IDLE, ISSUE and GAP.
REQ-021 SHALL move from IDLE to ISSUE when both FIFOs are non-empty.
REQ-022 SHALL, in ISSUE, pop both FIFOs, register both heads onto filter_in/desired_in, pulse filter_en and desired_en for exactly one cycle, and then go to GAP.
REQ-023 SHALL hold GAP for MIN_GAP-2 cycles, counted with a down-counter, then return to IDLE, so that en pulses are at least MIN_GAP cycles apart.
REQ-024 SHALL assert filter_en 2 cycles after the later of the two valid strobes when the FSM is in IDLE.
REQ-025 SHALL hold filter_in and desired_in stable between issues.
REQ-026 SHALL, when one FIFO is full while the other is empty, flush both FIFOs in that cycle, pulse resync, and discard any push in that cycle.
REQ-027 SHALL give flush priority over push, and push priority over the overflow flag.
REQ-028 SHALL give ovf_clr priority below a same-cycle set, so the flag stays 1.
REQ-029 SHALL preserve FIFO order per channel, with read and write pointers wrapping modulo DEPTH.

Reset
REQ-030 SHALL, on reset asserted mid-operation, immediately abandon any pair in flight, enter IDLE, empty both FIFOs and zero the gap counter.
REQ-031 SHALL drive filter_in=0, desired_in=0, filter_en=0, desired_en=0, both overflow flags=0 and resync=0 while reset is asserted.
REQ-032 SHALL ignore valid strobes while reset is asserted.

Configuration
REQ-033 SHALL, with LMS_PAIRER_STATS_EN defined, add output pair_cnt (16 bits), which increments on each issue, wraps 0xFFFF->0, and resets to 0.
REQ-034 SHALL, without LMS_PAIRER_STATS_EN, omit the pair_cnt port and counter, with all other behaviour unchanged.

Verification
REQ-035 SHALL cover this scenario: ref 0x1234 at cycle 10, mic 0xFEDC at cycle 14 -> filter_en/desired_en high at cycle 16 only, with filter_in=0x1234 and desired_in=0xFEDC.
REQ-036 SHALL cover this scenario: 3 pairs pushed back-to-back, MIN_GAP=272 -> en pulses 272 cycles apart, data in push order.
REQ-037 SHALL cover this scenario: DEPTH=8, 9 ref and 9 mic pushes with no issue possible (held in GAP) -> 9th sample of each channel dropped, both overflow flags=1, and ovf_clr returns them to 0.
REQ-038 SHALL cover this scenario: 8 ref pushes with 0 mic pushes -> resync pulse on the cycle after the 8th push, both FIFOs empty, and no filter_en.
REQ-039 SHALL cover this scenario: rst asserted asynchronously mid-GAP with 3 entries queued -> outputs 0 immediately, and after release a new pair issues 2 cycles after its strobes.
REQ-040 SHALL cover this scenario: with LMS_PAIRER_STATS_EN, 65537 issues -> pair_cnt=1.
